// File: rtl/pdm_pkg.sv
// rtl/pdm_pkg.sv - shared PCM/PDM constants for the modulator and decimator
package pdm_pkg;

  localparam int          PCM_W        = 16;
  localparam logic [15:0] PCM_OFFSET   = 16'h8000;
  localparam int          DEF_DIVCOUNT = 25;
  localparam int          DEF_OSR      = 64;

  // Signed two's-complement to offset binary (0..65535).
  function automatic logic [PCM_W-1:0] to_offset(input logic [PCM_W-1:0] s);
    return s ^ PCM_OFFSET;
  endfunction

endpackage

// File: rtl/pdm_fifo2.sv
// rtl/pdm_fifo2.sv - 2-entry PCM sample FIFO; push ignored when full, pop ignored when empty
module pdm_fifo2
  import pdm_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [PCM_W-1:0] data_i,
  input  logic             pop_i,
  output logic [PCM_W-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [1:0]       count_o
);

  logic [PCM_W-1:0] mem_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ~wr_ptr_q;
    if (do_pop)  rd_ptr_d = ~rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/pdm_tx_modulator.sv
// rtl/pdm_tx_modulator.sv - first-order sigma-delta PCM to PDM modulator with bit-clock divider
module pdm_tx_modulator
  import pdm_pkg::*;
#(
  parameter int DIVCOUNT = DEF_DIVCOUNT,
  parameter int OSR      = DEF_OSR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PCM_W-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             pdm_clk,
  output logic             pdm_o,
  output logic             underrun
);

  localparam int             CW       = $clog2(DIVCOUNT);
  localparam int             BW       = $clog2(OSR);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(DIVCOUNT - 1);
  localparam logic [CW-1:0]  CNT_HALF = CW'(DIVCOUNT / 2);
  localparam logic [BW-1:0]  BCNT_MAX = BW'(OSR - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [15:0]      acc_q, acc_d;
  logic [PCM_W-1:0] cur_q, cur_d;
  logic             pdm_q, pdm_d;
  logic             pclk_q, pclk_d;
  logic             ur_q, ur_d;
  logic             ready_q, ready_d;
  logic             run_q, run_d;

  logic             tick, boundary, push, pop;
  logic [16:0]      sum;
  logic [PCM_W-1:0] fifo_data;
  logic             fifo_full, fifo_empty;
  logic [1:0]       fifo_count;

  assign tick     = (cnt_q == CNT_MAX);
  assign boundary = tick && (bcnt_q == BCNT_MAX);
  assign push     = din_valid && ready_q;
  assign pop      = boundary && !fifo_empty;
  assign sum      = {1'b0, acc_q} + {1'b0, to_offset(cur_q)};

  pdm_fifo2 u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  (din),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    bcnt_d = bcnt_q;
    acc_d  = acc_q;
    cur_d  = cur_q;
    pdm_d  = pdm_q;
    ur_d   = 1'b0;
    run_d  = run_q;
    if (tick) begin
      cnt_d  = '0;
      run_d  = 1'b1;
      acc_d  = sum[15:0];
      pdm_d  = sum[16];
      bcnt_d = (bcnt_q == BCNT_MAX) ? '0 : bcnt_q + 1'b1;
    end
    // The boundary bit above still used the old sample; the popped one starts next tick.
    if (boundary) begin
      if (!fifo_empty) cur_d = fifo_data;
      else             ur_d  = 1'b1;
    end
    // Held low until the first tick so the receiver never sees a bit before the first real one.
    pclk_d  = run_d && (cnt_d < CNT_HALF);
    ready_d = !((fifo_full && !pop) || ((fifo_count == 2'd1) && push && !pop));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      bcnt_q  <= '0;
      acc_q   <= '0;
      cur_q   <= '0;
      pdm_q   <= 1'b0;
      pclk_q  <= 1'b0;
      ur_q    <= 1'b0;
      ready_q <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      acc_q   <= acc_d;
      cur_q   <= cur_d;
      pdm_q   <= pdm_d;
      pclk_q  <= pclk_d;
      ur_q    <= ur_d;
      ready_q <= ready_d;
      run_q   <= run_d;
    end
  end

  assign din_ready = ready_q;
  assign pdm_clk   = pclk_q;
  assign pdm_o     = pdm_q;
  assign underrun  = ur_q;

endmodule

// File: tb/tb_pdm_tx_modulator.sv
// tb/tb_pdm_tx_modulator.sv - randomized and directed self-checking bench for pdm_tx_modulator
module tb_pdm_tx_modulator;

  localparam int D   = 6;
  localparam int OSR = 8;
  localparam int FR  = D * OSR;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] din = 16'h0;
  logic        din_valid = 1'b0;
  logic        din_ready, pdm_clk, pdm_o, underrun;

  always #5 clk = ~clk;

  pdm_tx_modulator #(.DIVCOUNT(D), .OSR(OSR)) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .pdm_clk   (pdm_clk),
    .pdm_o     (pdm_o),
    .underrun  (underrun)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: sample queue, offset-binary accumulator, bit/frame positions as integers.
  int          m_cnt = 0, m_bcnt = 0, m_acc = 0, m_cur = 0;
  logic [15:0] m_q[$];
  bit          m_started = 0;
  logic        e_pdm = 0, e_pclk = 0, e_ur = 0, e_ready = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt = 0; m_bcnt = 0; m_acc = 0; m_cur = 0; m_started = 0;
      m_q.delete();
      e_pdm = 0; e_pclk = 0; e_ur = 0; e_ready = 0;
    end else begin
      bit tick, bnd, push;
      int s;
      tick = (m_cnt == D - 1);
      bnd  = tick && (m_bcnt == OSR - 1);
      push = din_valid && e_ready;
      e_ur = 0;
      if (tick) begin
        s      = m_acc + m_cur + 32768;
        e_pdm  = (s >= 65536);
        m_acc  = s % 65536;
        m_bcnt = (m_bcnt + 1) % OSR;
      end
      if (bnd) begin
        if (m_q.size() > 0) m_cur = int'($signed(m_q.pop_front()));
        else                e_ur = 1;
      end
      if (push) m_q.push_back(din);
      m_cnt     = tick ? 0 : m_cnt + 1;
      m_started = m_started || tick;
      e_pclk    = m_started && (m_cnt < D / 2);
      e_ready   = (m_q.size() < 2);
    end
  end

  int   kcyc = 0;
  always @(posedge clk) begin
    if (reset) kcyc = 0;
    else       kcyc++;
  end

  logic bitlog[$];
  int   ur_cnt = 0;
  logic prev_pclk = 1'b0;

  always @(negedge clk) begin
    check("pdm_o", pdm_o, e_pdm);
    check("pdm_clk", pdm_clk, e_pclk);
    check("underrun", underrun, e_ur);
    check("din_ready", din_ready, e_ready);
    if (!reset) begin
      if (prev_pclk && !pdm_clk) bitlog.push_back(pdm_o);
      if (underrun) ur_cnt++;
    end
    prev_pclk = pdm_clk;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    din_valid = 1'b0;
    step(3);
    check("ready_in_reset", din_ready, 0);
    bitlog.delete();
    ur_cnt = 0;
    reset = 1'b0;
  endtask

  task automatic wait_k(input int k);
    int g = 0;
    while (kcyc < k && g < 20000) begin
      step();
      g++;
    end
  endtask

  task automatic wait_bits(input int n);
    int g = 0;
    while (bitlog.size() < n && g < 4 * n * D + 4 * FR) begin
      step();
      g++;
    end
    if (bitlog.size() < n) check("bits_timeout", bitlog.size(), n);
  endtask

  task automatic push1(input logic [15:0] v);
    int g = 0;
    din = v;
    din_valid = 1'b1;
    while (!din_ready && g < 4 * FR) begin
      step();
      g++;
    end
    if (!din_ready) check("push_timeout", din_ready, 1);
    step();
    din_valid = 1'b0;
  endtask

  function automatic int ones(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (bitlog[i] === 1'b1) n++;
    return n;
  endfunction

  initial begin
    int first_rise, errs;

    // Reset with din_valid toggling, then release timing.
    for (int i = 0; i < 6; i++) begin
      din_valid = i[0];
      din = 16'h1234;
      step();
    end
    din_valid = 1'b0;
    check("ready_in_reset0", din_ready, 0);
    reset = 1'b0;
    step();
    check("ready_after_release", din_ready, 1);
    first_rise = pdm_clk ? 1 : 0;
    for (int k = 2; k <= D + 2 && first_rise == 0; k++) begin
      step();
      if (pdm_clk) first_rise = k;
    end
    check("first_rise_cycle", first_rise, D);

    // Maximum: frame 0 from reset value, frame 1 is one zero then ones.
    do_reset();
    push1(16'h7fff);
    wait_bits(2 * OSR);
    check("frame0_bit0", bitlog[0], 0);
    check("frame0_bit1", bitlog[1], 1);
    check("max_first_bit", bitlog[OSR], 0);
    check("max_ones", ones(OSR, 2 * OSR - 1), OSR - 1);

    // Mid-scale alternates.
    do_reset();
    din = 16'h0000;
    din_valid = 1'b1;
    wait_bits(3 * OSR);
    din_valid = 1'b0;
    errs = 0;
    for (int i = OSR; i < 3 * OSR; i++) if (bitlog[i] !== 1'(i % 2)) errs++;
    check("mid_alt_errs", errs, 0);

    // Minimum is all zeros.
    do_reset();
    din = 16'h8000;
    din_valid = 1'b1;
    wait_bits(3 * OSR);
    din_valid = 1'b0;
    check("min_ones", ones(OSR, 3 * OSR - 1), 0);

    // Backpressure and ordering.
    do_reset();
    din = 16'h8000;
    din_valid = 1'b1;
    step();
    check("bp_ready1", din_ready, 1);
    step();
    din = 16'h7fff;
    check("bp_ready2", din_ready, 1);
    step();
    din = 16'h0000;
    check("bp_ready3", din_ready, 0);
    wait_k(FR - 1);
    check("bp_before_pop", din_ready, 0);
    step();
    check("bp_after_pop", din_ready, 1);
    step();
    din_valid = 1'b0;
    wait_bits(3 * OSR);
    check("bp_order_a", ones(OSR, 2 * OSR - 1), 0);
    check("bp_order_b", ones(2 * OSR, 3 * OSR - 1), OSR - 1);

    // Underrun holds the last sample.
    do_reset();
    push1(16'd8192);
    wait_k(5 * FR + 2);
    check("ur_count", ur_cnt, 4);
    push1(16'd8192);
    wait_k(6 * FR + 2);
    check("ur_resume", ur_cnt, 4);
    check("ur_density", ones(OSR, 5 * OSR - 1), (5 * 4 * OSR) / 8);

    // Randomized traffic with one mid-frame reset.
    do_reset();
    for (int c = 0; c < 60 * FR; c++) begin
      din       = 16'($urandom);
      din_valid = ($urandom_range(0, 39) == 0);
      if (c == 30 * FR + 17) reset = 1'b1;
      if (c == 30 * FR + 19) reset = 1'b0;
      step();
    end
    din_valid = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
